// File: rtl/tcp_pkg.sv
// Shared constants, descriptor payload and state encoding for the TCP transmit path.
package tcp_pkg;

   localparam int unsigned HDR_BYTES      = 54;
   localparam int unsigned HDR_BITS       = HDR_BYTES * 8;
   localparam int unsigned HDR_PAD_BITS   = 512;
   localparam int unsigned HDR_MIX_OFF    = 48;
   localparam int unsigned HDR_LAST_BEAT  = 5;
   localparam int unsigned IP_HDR_WORDS   = 10;

   localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
   localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
   localparam logic [15:0] IP_TCP_HDR_LEN = 16'd40;
   localparam logic [7:0]  TCP_DATA_OFF   = 8'h50;

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [31:0] dst_ip;
      logic [31:0] src_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [31:0] seq;
      logic [31:0] ack;
      logic [7:0]  flags;
      logic [15:0] window;
      logic [15:0] tcp_csum;
      logic [15:0] pay_len;
      logic [15:0] ip_id;
   } tcp_desc_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CSUM, ST_HDR, ST_MIX, ST_PAY, ST_FLUSH
   } tx_state_e;

endpackage

// File: rtl/tcp_ip_csum.sv
// Combinational IPv4 header checksum: one's-complement sum of ten words, fold twice, invert.
module tcp_ip_csum
   import tcp_pkg::*;
(
   input  logic [16*IP_HDR_WORDS-1:0] hdr_words_i,
   output logic [15:0]                csum_o
);

   logic [19:0] sum;
   logic [16:0] fold1;
   logic [15:0] fold2;

   always_comb begin
      sum = '0;
      for (int i = 0; i < int'(IP_HDR_WORDS); i++) begin
         sum = sum + 20'(hdr_words_i[16*i +: 16]);
      end
      fold1  = 17'(sum[15:0]) + 17'(sum[19:16]);
      fold2  = fold1[15:0] + 16'(fold1[16]);
      csum_o = ~fold2;
   end

endmodule

// File: rtl/tcp_tx_framer.sv
// Builds an Ethernet II + IPv4 + TCP frame from one descriptor and a 64-bit payload stream.
module tcp_tx_framer
   import tcp_pkg::*;
#(
   parameter logic [7:0]  IP_TTL     = 8'd64,
   parameter logic [15:0] IP_ID_INIT = 16'h0000
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic [47:0] our_mac_addr_i,
   input  logic [31:0] our_ip_addr_i,
   input  logic        desc_valid_i,
   output logic        desc_ready_o,
   input  logic [47:0] desc_dst_mac_i,
   input  logic [31:0] desc_dst_ip_i,
   input  logic [15:0] desc_src_port_i,
   input  logic [15:0] desc_dst_port_i,
   input  logic [31:0] desc_seq_i,
   input  logic [31:0] desc_ack_i,
   input  logic [7:0]  desc_flags_i,
   input  logic [15:0] desc_window_i,
   input  logic [15:0] desc_tcp_csum_i,
   input  logic [15:0] desc_pay_len_i,
   input  logic [63:0] pay_tdata_i,
   input  logic [7:0]  pay_tkeep_i,
   input  logic        pay_tvalid_i,
   input  logic        pay_tlast_i,
   output logic        pay_tready_o,
   output logic [63:0] out_tdata_o,
   output logic [7:0]  out_tkeep_o,
   output logic        out_tvalid_o,
   output logic        out_tlast_o,
   input  logic        out_tready_i
);

   tx_state_e   state_q, state_d;
   tcp_desc_t   desc_q, desc_d;
   logic [15:0] csum_q, csum_d, csum_c;
   logic [2:0]  beat_q, beat_d;
   logic [47:0] resid_data_q, resid_data_d;
   logic [5:0]  resid_keep_q, resid_keep_d;
   logic [15:0] ip_id_q, ip_id_d;
   logic        desc_ready_q, desc_ready_d;
   logic [63:0] out_data_q, out_data_d;
   logic [7:0]  out_keep_q, out_keep_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;

   logic [15:0]             tot_len;
   logic [HDR_BITS-1:0]     hdr_be;
   logic [HDR_PAD_BITS-1:0] hdr_le;
   logic [47:0]             hdr_mix;
   logic [47:0]             lo_data;
   logic [5:0]              lo_keep;
   logic                    out_adv;
   logic                    mix_pay;
   logic                    pay_fire;

   assign tot_len = IP_TCP_HDR_LEN + desc_q.pay_len;

   // Header in wire order, byte 0 in the MSBs.
   assign hdr_be = {desc_q.dst_mac, desc_q.src_mac, ETH_TYPE_IPV4,
                    IP_VER_IHL, 8'h00, tot_len, desc_q.ip_id, IP_FLAGS_DF,
                    IP_TTL, IP_PROTO_TCP, csum_q, desc_q.src_ip, desc_q.dst_ip,
                    desc_q.src_port, desc_q.dst_port, desc_q.seq, desc_q.ack,
                    TCP_DATA_OFF, desc_q.flags, desc_q.window, desc_q.tcp_csum, 16'h0000};

   // Byte-reverse so wire byte i sits in lane bits [8i+7:8i].
   always_comb begin
      hdr_le = '0;
      for (int i = 0; i < int'(HDR_BYTES); i++) begin
         hdr_le[8*i +: 8] = hdr_be[8*(int'(HDR_BYTES) - 1 - i) +: 8];
      end
   end

   assign hdr_mix = hdr_le[8*HDR_MIX_OFF +: 48];

   tcp_ip_csum u_csum (
      .hdr_words_i ({IP_VER_IHL, 8'h00, tot_len, desc_q.ip_id, IP_FLAGS_DF,
                     IP_TTL, IP_PROTO_TCP, 16'h0000, desc_q.src_ip, desc_q.dst_ip}),
      .csum_o      (csum_c)
   );

   assign out_adv      = !out_valid_q || out_tready_i;
   assign mix_pay      = (state_q == ST_MIX) && (desc_q.pay_len != 16'd0);
   assign pay_tready_o = (mix_pay || (state_q == ST_PAY)) && out_adv;
   assign pay_fire     = pay_tready_o && pay_tvalid_i;
   assign lo_data      = (state_q == ST_MIX) ? hdr_mix : resid_data_q;
   assign lo_keep      = (state_q == ST_MIX) ? 6'h3F : resid_keep_q;

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q      <= ST_IDLE;
         desc_q       <= '0;
         csum_q       <= '0;
         beat_q       <= '0;
         resid_data_q <= '0;
         resid_keep_q <= '0;
         ip_id_q      <= IP_ID_INIT;
         desc_ready_q <= 1'b0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         desc_q       <= desc_d;
         csum_q       <= csum_d;
         beat_q       <= beat_d;
         resid_data_q <= resid_data_d;
         resid_keep_q <= resid_keep_d;
         ip_id_q      <= ip_id_d;
         desc_ready_q <= desc_ready_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      desc_d       = desc_q;
      csum_d       = csum_q;
      beat_d       = beat_q;
      resid_data_d = resid_data_q;
      resid_keep_d = resid_keep_q;
      ip_id_d      = ip_id_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      if (out_adv) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (desc_valid_i && desc_ready_q) begin
               desc_d.dst_mac  = desc_dst_mac_i;
               desc_d.src_mac  = our_mac_addr_i;
               desc_d.dst_ip   = desc_dst_ip_i;
               desc_d.src_ip   = our_ip_addr_i;
               desc_d.src_port = desc_src_port_i;
               desc_d.dst_port = desc_dst_port_i;
               desc_d.seq      = desc_seq_i;
               desc_d.ack      = desc_ack_i;
               desc_d.flags    = desc_flags_i;
               desc_d.window   = desc_window_i;
               desc_d.tcp_csum = desc_tcp_csum_i;
               desc_d.pay_len  = desc_pay_len_i;
               desc_d.ip_id    = ip_id_q;
               ip_id_d         = ip_id_q + 16'd1;
               state_d         = ST_CSUM;
            end
         end
         ST_CSUM: begin
            csum_d  = csum_c;
            beat_d  = '0;
            state_d = ST_HDR;
         end
         ST_HDR: begin
            if (out_adv) begin
               out_data_d  = hdr_le[64*beat_q +: 64];
               out_keep_d  = 8'hFF;
               out_valid_d = 1'b1;
               beat_d      = beat_q + 3'd1;
               if (beat_q == 3'(HDR_LAST_BEAT)) state_d = ST_MIX;
            end
         end
         ST_MIX, ST_PAY: begin
            if ((state_q == ST_MIX) && !mix_pay) begin
               if (out_adv) begin
                  out_data_d  = {16'h0000, hdr_mix};
                  out_keep_d  = 8'h3F;
                  out_last_d  = 1'b1;
                  out_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end else if (pay_fire) begin
               // Low two payload lanes complete this beat; the upper six carry forward.
               out_data_d   = {pay_tdata_i[15:0], lo_data};
               out_keep_d   = {pay_tkeep_i[1:0], lo_keep};
               out_valid_d  = 1'b1;
               resid_data_d = pay_tdata_i[63:16];
               resid_keep_d = pay_tkeep_i[7:2];
               if (pay_tlast_i && (pay_tkeep_i[7:2] == 6'h00)) begin
                  out_last_d = 1'b1;
                  state_d    = ST_IDLE;
               end else if (pay_tlast_i) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_PAY;
               end
            end
         end
         ST_FLUSH: begin
            if (out_adv) begin
               out_data_d  = {16'h0000, resid_data_q};
               out_keep_d  = {2'b00, resid_keep_q};
               out_last_d  = 1'b1;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      desc_ready_d = (state_d == ST_IDLE);
   end

   assign desc_ready_o = desc_ready_q;
   assign out_tdata_o  = out_data_q;
   assign out_tkeep_o  = out_keep_q;
   assign out_tvalid_o = out_valid_q;
   assign out_tlast_o  = out_last_q;

endmodule

// File: tb/tb_tcp_tx_framer.sv
// Randomized bench for tcp_tx_framer against a byte-level frame model.
module tb_tcp_tx_framer;

   localparam logic [15:0] ID_INIT = 16'h1c46;

   typedef struct packed {
      logic [47:0] dmac;
      logic [31:0] dip;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [31:0] seq;
      logic [31:0] ack;
      logic [7:0]  flags;
      logic [15:0] win;
      logic [15:0] tcsum;
      logic [15:0] plen;
   } tb_desc_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] our_mac = 48'h0;
   logic [31:0] our_ip = 32'h0;
   logic        desc_valid = 1'b0;
   logic        desc_ready_o;
   tb_desc_t    dcur = '0;
   logic [63:0] pay_tdata = '0;
   logic [7:0]  pay_tkeep = '0;
   logic        pay_tvalid = 1'b0;
   logic        pay_tlast = 1'b0;
   logic        pay_tready_o;
   logic [63:0] out_tdata_o;
   logic [7:0]  out_tkeep_o;
   logic        out_tvalid_o;
   logic        out_tlast_o;
   logic        out_tready = 1'b1;

   tcp_tx_framer #(.IP_TTL(8'd64), .IP_ID_INIT(ID_INIT)) dut (
      .clock_i         (clk),
      .reset_ni        (rst_n),
      .our_mac_addr_i  (our_mac),
      .our_ip_addr_i   (our_ip),
      .desc_valid_i    (desc_valid),
      .desc_ready_o    (desc_ready_o),
      .desc_dst_mac_i  (dcur.dmac),
      .desc_dst_ip_i   (dcur.dip),
      .desc_src_port_i (dcur.sport),
      .desc_dst_port_i (dcur.dport),
      .desc_seq_i      (dcur.seq),
      .desc_ack_i      (dcur.ack),
      .desc_flags_i    (dcur.flags),
      .desc_window_i   (dcur.win),
      .desc_tcp_csum_i (dcur.tcsum),
      .desc_pay_len_i  (dcur.plen),
      .pay_tdata_i     (pay_tdata),
      .pay_tkeep_i     (pay_tkeep),
      .pay_tvalid_i    (pay_tvalid),
      .pay_tlast_i     (pay_tlast),
      .pay_tready_o    (pay_tready_o),
      .out_tdata_o     (out_tdata_o),
      .out_tkeep_o     (out_tkeep_o),
      .out_tvalid_o    (out_tvalid_o),
      .out_tlast_o     (out_tlast_o),
      .out_tready_i    (out_tready)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   tb_desc_t    dq [2];
   logic [7:0]  pay_mem [2][2048];
   logic [7:0]  exp_mem [2][2048];
   logic [7:0]  got_mem [2][2048];
   int          exp_len [2];
   logic [15:0] exp_id [2];
   int          got_len [2];
   int          got_beats [2];
   logic [7:0]  got_keep_last [2];
   int          hs_cyc [2];
   int          first_valid_cyc [2];
   int          tlast_hs_cyc [2];
   int          frames_done = 0;
   int          cur_bytes = 0;
   int          cur_beats = 0;
   bit          in_frame = 1'b0;
   int          keep_err = 0;
   int          stall_err = 0;
   bit          pay_seen = 1'b0;
   bit          rand_ready = 1'b0;
   bit          gaps = 1'b0;
   bit          abort_pay = 1'b0;
   logic [15:0] model_id = ID_INIT;
   logic [7:0]  hq [$];

   bit          prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic [7:0]  prev_keep;
   logic        prev_last;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial forever begin
      @(posedge clk); #1;
      out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: collect accepted bytes per frame, check keep shape and stall stability.
   always @(negedge clk) begin
      int s;
      s = frames_done % 2;
      if (!rst_n) begin
         in_frame   = 1'b0;
         cur_bytes  = 0;
         cur_beats  = 0;
         prev_stall = 1'b0;
      end else begin
         if (pay_tready_o) pay_seen = 1'b1;
         if (prev_stall && (!out_tvalid_o || out_tdata_o !== prev_data ||
                            out_tkeep_o !== prev_keep || out_tlast_o !== prev_last))
            stall_err++;
         prev_stall = out_tvalid_o && !out_tready;
         prev_data  = out_tdata_o;
         prev_keep  = out_tkeep_o;
         prev_last  = out_tlast_o;
         if (out_tvalid_o && !in_frame) begin
            in_frame = 1'b1;
            first_valid_cyc[s] = cyc;
         end
         if (out_tvalid_o && out_tready) begin
            for (int l = 0; l < 8; l++) begin
               if (out_tkeep_o[l] && cur_bytes < 2048) begin
                  got_mem[s][cur_bytes] = out_tdata_o[8*l +: 8];
                  cur_bytes++;
               end
            end
            if (!out_tlast_o && out_tkeep_o != 8'hFF) keep_err++;
            if (out_tlast_o && !(out_tkeep_o inside {8'h01, 8'h03, 8'h07, 8'h0F,
                                                     8'h1F, 8'h3F, 8'h7F, 8'hFF}))
               keep_err++;
            cur_beats++;
            if (out_tlast_o) begin
               got_len[s]       = cur_bytes;
               got_beats[s]     = cur_beats;
               got_keep_last[s] = out_tkeep_o;
               tlast_hs_cyc[s]  = cyc + 1;
               frames_done++;
               in_frame  = 1'b0;
               cur_bytes = 0;
               cur_beats = 0;
            end
         end
      end
   end

   function automatic void push_be(input logic [47:0] v, input int n);
      for (int k = n - 1; k >= 0; k--) hq.push_back(v[8*k +: 8]);
   endfunction

   task automatic build_expected(input int slot, input logic [15:0] id);
      int unsigned sum;
      logic [15:0] c;
      tb_desc_t d;
      d = dq[slot];
      hq.delete();
      push_be(d.dmac, 6);
      push_be(our_mac, 6);
      push_be(48'h0800, 2);
      push_be(48'h45, 1);
      push_be(48'h00, 1);
      push_be(48'(16'(16'd40 + d.plen)), 2);
      push_be(48'(id), 2);
      push_be(48'h4000, 2);
      push_be(48'd64, 1);
      push_be(48'd6, 1);
      push_be(48'h0, 2);
      push_be(48'(our_ip), 4);
      push_be(48'(d.dip), 4);
      push_be(48'(d.sport), 2);
      push_be(48'(d.dport), 2);
      push_be(48'(d.seq), 4);
      push_be(48'(d.ack), 4);
      push_be(48'h50, 1);
      push_be(48'(d.flags), 1);
      push_be(48'(d.win), 2);
      push_be(48'(d.tcsum), 2);
      push_be(48'h0, 2);
      sum = 0;
      for (int k = 0; k < 10; k++) sum += 32'({hq[14 + 2*k], hq[15 + 2*k]});
      while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
      c = ~sum[15:0];
      hq[24] = c[15:8];
      hq[25] = c[7:0];
      for (int i = 0; i < int'(d.plen); i++) hq.push_back(pay_mem[slot][i]);
      exp_len[slot] = hq.size();
      for (int i = 0; i < hq.size(); i++) exp_mem[slot][i] = hq[i];
   endtask

   task automatic new_desc(input int slot, input int len);
      dq[slot].dmac  = {16'($urandom), 32'($urandom)};
      dq[slot].dip   = 32'($urandom);
      dq[slot].sport = 16'($urandom);
      dq[slot].dport = 16'($urandom);
      dq[slot].seq   = 32'($urandom);
      dq[slot].ack   = 32'($urandom);
      dq[slot].flags = 8'($urandom);
      dq[slot].win   = 16'($urandom);
      dq[slot].tcsum = 16'($urandom);
      dq[slot].plen  = 16'(len);
      for (int i = 0; i < len; i++) pay_mem[slot][i] = 8'($urandom);
   endtask

   task automatic send_desc(input int slot);
      int g;
      g = 0;
      @(posedge clk); #1;
      dcur = dq[slot];
      desc_valid = 1'b1;
      @(negedge clk);
      while (!desc_ready_o && g < 3000) begin
         @(negedge clk);
         g++;
      end
      check_eq("desc_accept", 64'(desc_ready_o), 64'd1);
      hs_cyc[slot] = cyc + 1;
      exp_id[slot] = model_id;
      build_expected(slot, model_id);
      model_id = model_id + 16'd1;
      @(posedge clk); #1;
      desc_valid = 1'b0;
   endtask

   task automatic send_payload(input int slot, input int n);
      int idx;
      int guard;
      idx = 0;
      guard = 0;
      while (idx < n && !abort_pay && guard < 5000) begin
         @(posedge clk); #1;
         if (gaps && $urandom_range(0, 2) == 0) begin
            pay_tvalid = 1'b0;
         end else begin
            for (int l = 0; l < 8; l++) begin
               if (idx + l < n) begin
                  pay_tdata[8*l +: 8] = pay_mem[slot][idx + l];
                  pay_tkeep[l] = 1'b1;
               end else begin
                  pay_tdata[8*l +: 8] = 8'($urandom);
                  pay_tkeep[l] = 1'b0;
               end
            end
            pay_tlast  = (idx + 8 >= n);
            pay_tvalid = 1'b1;
         end
         @(negedge clk);
         if (pay_tvalid && pay_tready_o) idx += 8;
         guard++;
      end
      if (guard >= 5000) check_eq("pay_timeout", 64'(idx), 64'(n));
      @(posedge clk); #1;
      pay_tvalid = 1'b0;
      pay_tlast  = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int g;
      g = 0;
      while (frames_done < target && g < 3000) begin
         @(negedge clk);
         g++;
      end
      check_eq("frame_done", 64'(frames_done), 64'(target));
   endtask

   task automatic check_frame(input int slot);
      int mism;
      int rem;
      logic [7:0] ek;
      mism = 0;
      for (int i = 0; i < exp_len[slot] && i < got_len[slot]; i++)
         if (got_mem[slot][i] !== exp_mem[slot][i]) mism++;
      rem = exp_len[slot] % 8;
      ek  = (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
      check_eq("frame_bytes", 64'(mism), 64'd0);
      check_eq("frame_len", 64'(got_len[slot]), 64'(exp_len[slot]));
      check_eq("frame_beats", 64'(got_beats[slot]), 64'((exp_len[slot] + 7) / 8));
      check_eq("last_keep", 64'(got_keep_last[slot]), 64'(ek));
      check_eq("first_latency", 64'(first_valid_cyc[slot] - hs_cyc[slot]), 64'd2);
      check_eq("ip_id", 64'({got_mem[slot][18], got_mem[slot][19]}), 64'(exp_id[slot]));
   endtask

   task automatic run_frame(input int len);
      int slot;
      int target;
      slot   = frames_done % 2;
      target = frames_done + 1;
      new_desc(slot, len);
      fork
         send_desc(slot);
         send_payload(slot, len);
      join
      wait_frames(target);
      check_frame(slot);
   endtask

   function automatic logic [63:0] got_be(input int slot, input int off, input int n);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = {v[55:0], got_mem[slot][off + i]};
      return v;
   endfunction

   initial begin
      int s0;
      int s1;
      int target;
      int g;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ctrl", 64'({out_tvalid_o, out_tlast_o, out_tkeep_o}), 64'd0);
      check_eq("rst_data", out_tdata_o, 64'd0);
      check_eq("rst_ready", 64'({desc_ready_o, pay_tready_o}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_ready", 64'(desc_ready_o), 64'd1);

      // Known-good IPv4 header checksum.
      our_mac = 48'h0200_0000_0001;
      our_ip  = 32'hac10_0a63;
      s0 = frames_done % 2;
      new_desc(s0, 20);
      dq[s0].dip = 32'hac10_0a0c;
      target = frames_done + 1;
      fork
         send_desc(s0);
         send_payload(s0, 20);
      join
      wait_frames(target);
      check_frame(s0);
      check_eq("ip_hdr_a", got_be(s0, 14, 8), 64'h4500_003c_1c46_4000);
      check_eq("ip_hdr_b", got_be(s0, 22, 8), 64'h4006_b1e6_ac10_0a63);
      check_eq("ip_hdr_c", got_be(s0, 30, 4), 64'h0000_0000_ac10_0a0c);

      // Header-only frame never opens the payload port.
      pay_seen = 1'b0;
      run_frame(0);
      check_eq("len0_no_tready", 64'(pay_seen), 64'd0);

      run_frame(2);
      run_frame(10);

      // Random lengths with output back-pressure and payload gaps.
      our_mac = {16'($urandom), 32'($urandom)};
      our_ip  = 32'($urandom);
      rand_ready = 1'b1;
      gaps = 1'b1;
      run_frame(64);
      run_frame(1);
      run_frame(7);
      run_frame(8);
      run_frame(9);
      run_frame(16);
      run_frame(int'($urandom_range(1, 300)));
      run_frame(1460);
      rand_ready = 1'b0;
      gaps = 1'b0;

      // Back-to-back descriptors.
      s0 = frames_done % 2;
      s1 = 1 - s0;
      target = frames_done + 2;
      new_desc(s0, 5);
      new_desc(s1, 13);
      fork
         begin send_desc(s0); send_desc(s1); end
         begin send_payload(s0, 5); send_payload(s1, 13); end
      join
      wait_frames(target);
      check_frame(s0);
      check_frame(s1);
      check_eq("b2b_gap", 64'(first_valid_cyc[s1] - tlast_hs_cyc[s0]), 64'd2);

      // Reset during a payload beat, then a clean frame.
      s0 = frames_done % 2;
      new_desc(s0, 64);
      abort_pay = 1'b0;
      fork
         send_desc(s0);
         send_payload(s0, 64);
         begin
            g = 0;
            while (cur_beats < 10 && g < 3000) begin
               @(negedge clk);
               g++;
            end
            check_eq("reach_pay3", 64'(cur_beats), 64'd10);
            @(posedge clk); #1;
            rst_n = 1'b0;
            abort_pay = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("midrst_ctrl", 64'({out_tvalid_o, out_tlast_o, out_tkeep_o}), 64'd0);
            check_eq("midrst_data", out_tdata_o, 64'd0);
            check_eq("midrst_ready", 64'({desc_ready_o, pay_tready_o}), 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
      join
      abort_pay = 1'b0;
      model_id  = ID_INIT;
      run_frame(37);

      check_eq("keep_shape", 64'(keep_err), 64'd0);
      check_eq("stall_stable", 64'(stall_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
